// File: rtl/pll_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer_if
//
// Bundles the PLL-facing and reset-facing signals of the PLL reset sequencer.
//
//   pll_locked     PLL lock indication, asynchronous to the sequencer clock
//   pll_rst        active-high reset to the PLL
//   rst_seq_n      per-stage active-low resets; bit 0 is released first
//   seq_done       high while every stage is released
//   lock_lost_cnt  saturating count of lock losses after release began
//
// Modports:
//   slave   the sequencer itself (consumes pll_locked, drives the rest)
//   master  the surrounding system (drives pll_locked, observes the rest)
// -----------------------------------------------------------------------------
interface pll_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_locked;
    logic                  pll_rst;
    logic [NUM_STAGES-1:0] rst_seq_n;
    logic                  seq_done;
    logic [7:0]            lock_lost_cnt;

    modport master (
        output pll_locked,
        input  pll_rst,
        input  rst_seq_n,
        input  seq_done,
        input  lock_lost_cnt
    );

    modport slave (
        input  pll_locked,
        output pll_rst,
        output rst_seq_n,
        output seq_done,
        output lock_lost_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Qualifies the PLL lock indication and releases the downstream resets in
// order (SDRAM controller, bus fabric, CPU) with a fixed gap between stages.
// Every reset is reasserted on the edge a loss of lock is seen. Runs on the
// board reference clock so it keeps working while the PLL is unlocked.
//
// Ports:
//   clk    board reference clock (same net as the PLL refclk)
//   rst_n  asynchronous active-low reset
//   bus    pll_reset_sequencer_if.slave:
//            pll_locked (in), pll_rst, rst_seq_n, seq_done, lock_lost_cnt (out)
//
// Optional feature (macro PLL_RELOCK_RETRY_EN):
//   When defined, LOCK_TIMEOUT_CYCLES unlocked cycles in WAIT_LOCK trigger a
//   PLL_RST_CYCLES-long pll_rst pulse, retried indefinitely. When undefined,
//   pll_rst is tied low and WAIT_LOCK waits forever.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int NUM_STAGES          = 3,
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int PLL_RST_CYCLES      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_reset_sequencer_if.slave bus
);

    // Reject parameter sets the counter comparisons below cannot honour.
    if (NUM_STAGES < 1 || SYNC_STAGES < 2 || LOCK_STABLE_CYCLES < 2 ||
        STAGE_GAP_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1)
    begin : g_bad_params
        $error("pll_reset_sequencer: illegal parameter value");
    end

    localparam int QUAL_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES)
                            ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
`ifdef PLL_RELOCK_RETRY_EN
    localparam int RETRY_MAX = (LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES)
                             ? LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES;
    localparam int CNT_MAX   = (QUAL_MAX > RETRY_MAX) ? QUAL_MAX : RETRY_MAX;
`else
    localparam int CNT_MAX   = QUAL_MAX;
`endif
    // +1 so the counter can actually hold the timeout value itself.
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STAGES - 1);
`ifdef PLL_RELOCK_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
`endif

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
`ifdef PLL_RELOCK_RETRY_EN
    localparam logic [2:0] PLL_RST   = 3'd4;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [NUM_STAGES-1:0]  rst_seq_q;
    logic                   seq_done_q;
    logic [7:0]             lost_cnt_q;

    // pll_locked is asynchronous to clk; only the last flop of the chain is
    // ever looked at.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_RELOCK_RETRY_EN
    logic pll_rst_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            idx        <= '0;
            rst_seq_q  <= '0;
            seq_done_q <= 1'b0;
            lost_cnt_q <= '0;
`ifdef PLL_RELOCK_RETRY_EN
            pll_rst_q  <= 1'b0;
`endif
        end else if ((state == RELEASE || state == RUN) && !locked_s) begin
            // Lock lost after release began: drop every stage at once.
            state      <= WAIT_LOCK;
            cnt        <= '0;
            idx        <= '0;
            rst_seq_q  <= '0;
            seq_done_q <= 1'b0;
            if (lost_cnt_q != 8'hFF) begin
                lost_cnt_q <= lost_cnt_q + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        // This edge is the first qualifying sample.
                        state <= STABLE;
                        cnt   <= CNT_ONE;
`ifdef PLL_RELOCK_RETRY_EN
                    end else if (cnt == TIMEOUT_VAL) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
`endif
                    end
                end

                STABLE: begin
                    if (!locked_s) begin
                        // Glitch inside the qualification window: restart only.
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        rst_seq_q[0] <= 1'b1;
                        cnt          <= '0;
                        idx          <= IDX_ONE;
                        if (NUM_STAGES == 1) begin
                            seq_done_q <= 1'b1;
                            state      <= RUN;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        rst_seq_q[idx] <= 1'b1;
                        idx            <= idx + IDX_ONE;
                        cnt            <= '0;
                        if (idx == LAST_IDX) begin
                            seq_done_q <= 1'b1;
                            state      <= RUN;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RUN: begin
                end

`ifdef PLL_RELOCK_RETRY_EN
                PLL_RST: begin
                    // locked_s is deliberately ignored while the PLL is held.
                    if (cnt == PULSE_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif

                default: begin
                    state      <= WAIT_LOCK;
                    cnt        <= '0;
                    idx        <= '0;
                    rst_seq_q  <= '0;
                    seq_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RELOCK_RETRY_EN
    assign bus.pll_rst = pll_rst_q;
`else
    assign bus.pll_rst = 1'b0;
`endif
    assign bus.rst_seq_n     = rst_seq_q;
    assign bus.seq_done      = seq_done_q;
    assign bus.lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with short timing parameters.
// Each task drives one scenario and checks hand-computed expectations; a
// negedge monitor also checks release ordering and seq_done consistency.
// Compile with +define+PLL_RELOCK_RETRY_EN to exercise the retry pulse.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int NUM_STAGES          = 3;
    localparam int SYNC_STAGES         = 2;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int STAGE_GAP_CYCLES    = 4;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int PLL_RST_CYCLES      = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pll_reset_sequencer_if #(.NUM_STAGES(NUM_STAGES)) bus ();

    pll_reset_sequencer #(
        .NUM_STAGES          (NUM_STAGES),
        .SYNC_STAGES         (SYNC_STAGES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .STAGE_GAP_CYCLES    (STAGE_GAP_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .PLL_RST_CYCLES      (PLL_RST_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observation word: {rst_seq_n, seq_done, pll_rst, lock_lost_cnt}.
    logic [12:0] obs;
    assign obs = {bus.rst_seq_n, bus.seq_done, bus.pll_rst, bus.lock_lost_cnt};

    function automatic logic [12:0] pack(input logic [2:0] r, input logic d,
                                         input logic p, input logic [7:0] c);
        return {r, d, p, c};
    endfunction

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ordering monitor: only 000/001/011/111 are legal and seq_done must
    // match "all released".
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!(bus.rst_seq_n inside {3'b000, 3'b001, 3'b011, 3'b111}) ||
                bus.seq_done !== (bus.rst_seq_n == 3'b111)) begin
                failures++;
                $display("FAIL order_monitor rst_seq_n=%b seq_done=%b at %0t",
                         bus.rst_seq_n, bus.seq_done, $time);
            end
        end
    end

    task automatic test_reset();
        logic [12:0] exp;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        #3;
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_initial got=%b want=%b", obs, exp);
        end
        step(3);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", obs, exp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        logic [12:0] exp;
        bus.pll_locked = 1'b1;          // G0..G4 sample high
        step(5);
        bus.pll_locked = 1'b0;          // G5 samples low
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_before_drop got=%b want=%b", obs, exp);
        end
        step(1);
        bus.pll_locked = 1'b1;          // final rise: next edge is E0
        step(2);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_during got=%b want=%b", obs, exp);
        end
        step(7);                        // after E0+8
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_e8 got=%b want=%b", obs, exp);
        end
        step(1);                        // after E0+9
        exp = pack(3'b001, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_e9 got=%b want=%b", obs, exp);
        end
        step(8);                        // after E0+17
        exp = pack(3'b111, 1'b1, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_e17 got=%b want=%b", obs, exp);
        end
    endtask

    task automatic test_loss_in_run();
        logic [12:0] exp;
        bus.pll_locked = 1'b0;          // D0 samples low
        step(2);                        // after D1: not yet seen
        exp = pack(3'b111, 1'b1, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL run_loss_d1 got=%b want=%b", obs, exp);
        end
        step(1);                        // after D2: all cleared
        exp = pack(3'b000, 1'b0, 1'b0, 8'd1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL run_loss_d2 got=%b want=%b", obs, exp);
        end
        bus.pll_locked = 1'b1;          // relock, next edge is E0
        step(9);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL relock_e8 got=%b want=%b", obs, exp);
        end
        step(1);
        exp = pack(3'b001, 1'b0, 1'b0, 8'd1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL relock_e9 got=%b want=%b", obs, exp);
        end
        step(8);
        exp = pack(3'b111, 1'b1, 1'b0, 8'd1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL relock_e17 got=%b want=%b", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] exp;
        rst_n = 1'b0;                   // mid-cycle, no clock edge before check
        #2;
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL async_reset_immediate got=%b want=%b", obs, exp);
        end
        step(2);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL async_reset_held got=%b want=%b", obs, exp);
        end
        rst_n = 1'b1;                   // pll_locked still high
    endtask

    task automatic test_clean_lock();
        logic [12:0] exp;
        step(9);                        // after E8
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e8 got=%b want=%b", obs, exp);
        end
        step(1);
        exp = pack(3'b001, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e9 got=%b want=%b", obs, exp);
        end
        step(3);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e12 got=%b want=%b", obs, exp);
        end
        step(1);
        exp = pack(3'b011, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e13 got=%b want=%b", obs, exp);
        end
        step(3);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e16 got=%b want=%b", obs, exp);
        end
        step(1);
        exp = pack(3'b111, 1'b1, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_e17 got=%b want=%b", obs, exp);
        end
    endtask

    task automatic test_loss_mid_release();
        logic [12:0] exp;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        step(2);
        rst_n          = 1'b1;
        bus.pll_locked = 1'b1;
        step(14);                       // after E13
        exp = pack(3'b011, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_e13 got=%b want=%b", obs, exp);
        end
        bus.pll_locked = 1'b0;
        step(2);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_loss_l1 got=%b want=%b", obs, exp);
        end
        step(1);
        exp = pack(3'b000, 1'b0, 1'b0, 8'd1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_loss_l2 got=%b want=%b", obs, exp);
        end
        // 254 further losses from RELEASE bring the count to 255.
        for (int i = 0; i < 254; i++) begin
            bus.pll_locked = 1'b1;
            step(10);
            bus.pll_locked = 1'b0;
            step(3);
        end
        exp = pack(3'b000, 1'b0, 1'b0, 8'd255);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL lost_cnt_255 got=%b want=%b", obs, exp);
        end
        // The 256th loss must saturate.
        bus.pll_locked = 1'b1;
        step(10);
        exp = pack(3'b001, 1'b0, 1'b0, 8'd255);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL sat_release got=%b want=%b", obs, exp);
        end
        bus.pll_locked = 1'b0;
        step(3);
        exp = pack(3'b000, 1'b0, 1'b0, 8'd255);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL lost_cnt_saturate got=%b want=%b", obs, exp);
        end
    endtask

    task automatic test_retry();
        logic [12:0] exp;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        step(2);
        rst_n = 1'b1;                   // next edge is E0
`ifdef PLL_RELOCK_RETRY_EN
        step(32);                       // after E31
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e31 got=%b want=%b", obs, exp);
        end
        step(1);                        // after E32: pulse starts
        exp = pack(3'b000, 1'b0, 1'b1, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e32 got=%b want=%b", obs, exp);
        end
        step(3);                        // after E35: still high
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e35 got=%b want=%b", obs, exp);
        end
        step(1);                        // after E36: pulse over
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e36 got=%b want=%b", obs, exp);
        end
        step(32);                       // after E68
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e68 got=%b want=%b", obs, exp);
        end
        step(1);                        // after E69: second pulse
        exp = pack(3'b000, 1'b0, 1'b1, 8'd0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL retry_e69 got=%b want=%b", obs, exp);
        end
`else
        exp = pack(3'b000, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 80; i++) begin
            step(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL no_retry_edge%0d got=%b want=%b", i, obs, exp);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_loss_in_run();
        test_async_reset();
        test_clean_lock();
        test_loss_mid_release();
        test_retry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
